// File: rtl/blink_control.sv
// blink_control: two active-low push-buttons drive an LED bank.
// button_0 cycles the display mode OFF -> SOLID -> BLINK -> CHASE -> OFF.
// button_1 toggles between the normal and fast animation rates.
// Each raw button is synchronised (2 flops) and debounced before use.
module blink_control #(
  parameter int LED_W    = 3,
  parameter int CLK_DIV  = 8,
  parameter int DEBOUNCE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button_0,
  input  logic             button_1,
  output logic [LED_W-1:0] led,
  output logic [1:0]       mode,
  output logic             fast
);

  // Debounce counter only has to reach DEBOUNCE.
  localparam int DB_W = $clog2(DEBOUNCE + 1);
  // Fast rate halves the period but never drops below one cycle.
  localparam int P_FAST = ((CLK_DIV >> 1) > 1) ? (CLK_DIV >> 1) : 1;
  localparam int TK_W   = $clog2(CLK_DIV);

  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE - 1);
  localparam logic [TK_W-1:0] TOP_NORM = TK_W'(CLK_DIV - 1);
  localparam logic [TK_W-1:0] TOP_FAST = TK_W'(P_FAST - 1);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_SOLID = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_CHASE = 2'd3
  } mode_e;

  // Index 0 is button_0 (mode), index 1 is button_1 (rate).
  logic [1:0]            r_sync1;
  logic [1:0]            r_sync2;
  logic [1:0]            r_deb;
  logic [1:0]            r_deb_d;
  logic [1:0][DB_W-1:0]  r_db_cnt;

  mode_e                 r_mode;
  logic                  r_fast;
  logic [TK_W-1:0]       r_tick_cnt;
  logic                  r_phase;
  logic [LED_W-1:0]      r_pattern;
  logic [LED_W-1:0]      r_led;

  logic [1:0]            w_press;
  logic                  w_change;
  logic                  w_tick;
  logic                  w_enter_blink;
  logic                  w_enter_chase;

  // LED drive value for a given mode and animation state.
  function automatic logic [LED_W-1:0] f_led_value(
    input mode_e            m,
    input logic             ph,
    input logic [LED_W-1:0] pat
  );
    logic [LED_W-1:0] v;
    case (m)
      MODE_OFF:   v = {LED_W{1'b0}};
      MODE_SOLID: v = {LED_W{1'b1}};
      MODE_BLINK: v = {LED_W{ph}};
      MODE_CHASE: v = pat;
      default:    v = {LED_W{1'b0}};
    endcase
    return v;
  endfunction

  // Synchronise the raw pins and debounce them into stable levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= 2'b11;
      r_sync2  <= 2'b11;
      r_deb    <= 2'b11;
      r_deb_d  <= 2'b11;
      r_db_cnt <= '0;
    end else begin
      r_sync1 <= {button_1, button_0};
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      for (int b = 0; b < 2; b++) begin
        if (r_sync2[b] != r_deb[b]) begin
          if (r_db_cnt[b] == DB_LAST) begin
            r_deb[b]    <= r_sync2[b];
            r_db_cnt[b] <= {DB_W{1'b0}};
          end else begin
            r_db_cnt[b] <= r_db_cnt[b] + DB_W'(1);
          end
        end else begin
          r_db_cnt[b] <= {DB_W{1'b0}};
        end
      end
    end
  end

  // Press events, tick strobe and mode-entry strobes.
  always_comb begin
    // A press is the debounced level falling 1 -> 0 (buttons are active-low).
    w_press       = r_deb_d & ~r_deb;
    w_change      = w_press[0] | w_press[1];
    w_tick        = (r_tick_cnt == (r_fast ? TOP_FAST : TOP_NORM));
    w_enter_blink = w_press[0] & (r_mode == MODE_SOLID);
    w_enter_chase = w_press[0] & (r_mode == MODE_BLINK);
  end

  // Mode FSM, rate flag, tick counter, animation state and LED register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode     <= MODE_OFF;
      r_fast     <= 1'b0;
      r_tick_cnt <= {TK_W{1'b0}};
      r_phase    <= 1'b1;
      r_pattern  <= {{(LED_W-1){1'b0}}, 1'b1};
      r_led      <= {LED_W{1'b0}};
    end else begin
      if (w_press[0]) begin
        case (r_mode)
          MODE_OFF:   r_mode <= MODE_SOLID;
          MODE_SOLID: r_mode <= MODE_BLINK;
          MODE_BLINK: r_mode <= MODE_CHASE;
          MODE_CHASE: r_mode <= MODE_OFF;
          default:    r_mode <= MODE_OFF;
        endcase
      end else begin
        r_mode <= r_mode;
      end

      r_fast <= r_fast ^ w_press[1];

      // Any mode or rate change restarts the period so the next tick is a full P away.
      if (w_change || w_tick) begin
        r_tick_cnt <= {TK_W{1'b0}};
      end else begin
        r_tick_cnt <= r_tick_cnt + TK_W'(1);
      end

      if (w_enter_blink) begin
        r_phase <= 1'b1;
      end else if (w_tick) begin
        r_phase <= ~r_phase;
      end else begin
        r_phase <= r_phase;
      end

      if (w_enter_chase) begin
        r_pattern <= {{(LED_W-1){1'b0}}, 1'b1};
      end else if (w_tick) begin
        r_pattern <= {r_pattern[LED_W-2:0], r_pattern[LED_W-1]};
      end else begin
        r_pattern <= r_pattern;
      end

      r_led <= f_led_value(r_mode, r_phase, r_pattern);
    end
  end

  assign led  = r_led;
  assign mode = r_mode;
  assign fast = r_fast;

endmodule

// File: tb/tb_blink_control.sv
// Directed bench for blink_control (LED_W=3, CLK_DIV=8, DEBOUNCE=4).
module tb_blink_control;

  logic       clk;
  logic       rst;
  logic       button_0;
  logic       button_1;
  logic [2:0] led;
  logic [1:0] mode;
  logic       fast;

  int n_tests;
  int n_fail;

  blink_control #(.LED_W(3), .CLK_DIV(8), .DEBOUNCE(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .button_0 (button_0),
    .button_1 (button_1),
    .led      (led),
    .mode     (mode),
    .fast     (fast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         b0_len;
    int         b1_len;
    logic [1:0] exp_mode;
    logic       exp_fast;
    logic       chk_led;
    logic [2:0] exp_led;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Buttons driven and outputs sampled on the falling edge.
  task automatic press_release(input int l0, input int l1);
    int lmax;
    lmax = (l0 > l1) ? l0 : l1;
    if (l0 > 0) button_0 = 1'b0;
    if (l1 > 0) button_1 = 1'b0;
    for (int i = 1; i <= lmax; i++) begin
      @(negedge clk);
      if (i == l0) button_0 = 1'b1;
      if (i == l1) button_1 = 1'b1;
    end
    repeat (20) @(negedge clk);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    button_0 = 1'b1;
    button_1 = 1'b1;

    //                b0  b1  mode  fast  chk   led
    vecs[0]  = '{ 3,  0, 2'd1, 1'b0, 1'b1, 3'b111};  // glitch ignored
    vecs[1]  = '{ 6,  0, 2'd2, 1'b0, 1'b0, 3'b000};  // short press accepted
    vecs[2]  = '{ 0, 20, 2'd2, 1'b1, 1'b0, 3'b000};
    vecs[3]  = '{ 0,  2, 2'd2, 1'b1, 1'b0, 3'b000};  // glitch on rate button
    vecs[4]  = '{20,  0, 2'd3, 1'b1, 1'b0, 3'b000};
    vecs[5]  = '{20, 20, 2'd0, 1'b0, 1'b1, 3'b000};  // both at once
    vecs[6]  = '{ 0,  5, 2'd0, 1'b1, 1'b1, 3'b000};
    vecs[7]  = '{ 4,  0, 2'd1, 1'b1, 1'b1, 3'b111};  // exactly DEBOUNCE long
    vecs[8]  = '{ 0,  8, 2'd1, 1'b0, 1'b1, 3'b111};
    vecs[9]  = '{20,  0, 2'd2, 1'b0, 1'b0, 3'b000};
    vecs[10] = '{20,  0, 2'd3, 1'b0, 1'b0, 3'b000};
    vecs[11] = '{20,  0, 2'd0, 1'b0, 1'b1, 3'b000};  // wrap to OFF

    // Reset held for 3 edges, then idle for 50 cycles.
    repeat (3) @(negedge clk);
    check("reset_state", {26'd0, mode, fast, led}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_after_reset", {26'd0, mode, fast, led}, 32'd0);
    end

    // Exact press latency: mode changes 7 edges after the raw falling edge.
    button_0 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 6) check("latency_mode_before", {30'd0, mode}, 32'd0);
      if (k == 7) begin
        check("latency_mode_at", {30'd0, mode}, 32'd1);
        check("latency_led_lag", {29'd0, led}, 32'd0);
      end
      if (k == 8) check("latency_led_solid", {29'd0, led}, 32'd7);
    end
    repeat (12) @(negedge clk);
    button_0 = 1'b1;
    repeat (20) @(negedge clk);
    check("release_no_event", {26'd0, mode, fast, led}, {26'd0, 2'd1, 1'b0, 3'b111});

    // Table of press patterns.
    for (int v = 0; v < 12; v++) begin
      press_release(vecs[v].b0_len, vecs[v].b1_len);
      check($sformatf("vec%0d_mode", v), {30'd0, mode}, {30'd0, vecs[v].exp_mode});
      check($sformatf("vec%0d_fast", v), {31'd0, fast}, {31'd0, vecs[v].exp_fast});
      if (vecs[v].chk_led) check($sformatf("vec%0d_led", v), {29'd0, led}, {29'd0, vecs[v].exp_led});
    end

    // BLINK timing at normal rate, then switch to fast.
    press_release(20, 0);
    button_0 = 1'b0;
    repeat (7) @(negedge clk);
    check("blink_enter_mode", {30'd0, mode}, 32'd2);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      check($sformatf("blink_norm_k%0d", k), {29'd0, led},
            (((k - 1) / 8) % 2 == 0) ? 32'd7 : 32'd0);
    end
    button_0 = 1'b1;
    button_1 = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      if (j == 6) check("blink_fast_before", {31'd0, fast}, 32'd0);
      if (j == 7) check("blink_fast_at", {31'd0, fast}, 32'd1);
    end
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      check($sformatf("blink_fast_j%0d", j), {29'd0, led},
            (((j - 1) / 4) % 2 == 0) ? 32'd0 : 32'd7);
    end
    button_1 = 1'b1;
    repeat (20) @(negedge clk);

    // CHASE timing at normal rate, then switch to fast.
    press_release(0, 20);
    check("chase_pre_fast", {31'd0, fast}, 32'd0);
    button_0 = 1'b0;
    repeat (7) @(negedge clk);
    check("chase_enter_mode", {30'd0, mode}, 32'd3);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      check($sformatf("chase_norm_k%0d", k), {29'd0, led},
            32'd1 << (((k - 1) / 8) % 3));
    end
    button_0 = 1'b1;
    button_1 = 1'b0;
    repeat (7) @(negedge clk);
    check("chase_fast_at", {31'd0, fast}, 32'd1);
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      check($sformatf("chase_fast_j%0d", j), {29'd0, led},
            32'd1 << ((1 + (j - 1) / 4) % 3));
    end
    button_1 = 1'b1;
    repeat (20) @(negedge clk);

    // Both buttons at once in CHASE with fast set: applied on the same edge.
    button_0 = 1'b0;
    button_1 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 6) check("simul_before", {29'd0, mode, fast}, {29'd0, 2'd3, 1'b1});
      if (k == 7) check("simul_at", {29'd0, mode, fast}, 32'd0);
      if (k == 8) check("simul_led", {29'd0, led}, 32'd0);
    end
    button_0 = 1'b1;
    button_1 = 1'b1;
    repeat (20) @(negedge clk);

    // Reset in the middle of CHASE.
    press_release(20, 0);
    press_release(20, 0);
    press_release(20, 0);
    press_release(0, 20);
    check("pre_reset_state", {29'd0, mode, fast}, {29'd0, 2'd3, 1'b1});
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_reset", {26'd0, mode, fast, led}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("reset_exit_quiet", {26'd0, mode, fast, led}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/blink_control.md
Name: blink_control

Overview:
- Parametrised successor to the single-button LED control block of the BLINK project.
- Drives an LED_W-bit LED bank from two active-low push-buttons.
- Each button input passes through a 2-flop synchroniser and a debouncer.
- button_0 steps a 4-mode display FSM: OFF, SOLID, BLINK, CHASE. button_1 toggles between normal and fast blink/chase rate.
- Sits directly between board pins and LED pins at top level.

Parameters:
LED_W, 3, number of LED outputs (>=2)
CLK_DIV, 8, clk cycles per animation tick in normal rate (>=2)
DEBOUNCE, 4, consecutive stable synchronised cycles required to accept a button level change (>=1)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
button_0  input  1  raw mode button, active-low (1 = released), asynchronous to clk
button_1  input  1  raw rate button, active-low, asynchronous to clk
led  output  LED_W  LED drive, 1 = on, registered
mode  output  2  current mode: 0 OFF, 1 SOLID, 2 BLINK, 3 CHASE, registered
fast  output  1  1 = fast rate selected, registered

Behaviour:
- Reset (rst high at a clk edge): mode=0, fast=0, led=0. Synchroniser flops=1, debounced levels=1, debounce counters=0, tick counter=0, blink phase=1, chase pattern=1. Reset mid-operation takes effect on the next edge; no press is generated on reset exit.
- Synchroniser: 2 flops per button. Latency 2 cycles.
- Debounce, per button:
  - While the synchronised value differs from the debounced level, the counter increments.
  - When the counter reaches DEBOUNCE, the debounced level updates and the counter clears.
  - Any cycle where the synchronised value equals the debounced level clears the counter, so glitches shorter than DEBOUNCE cycles are ignored.
  - A press event is a 1-cycle pulse on a debounced 1->0 transition. Releases generate no event. A held button generates exactly one event.
- Mode FSM:
  - On a button_0 event, mode advances on the next edge: 0->1->2->3->0 (wraps).
  - On a button_1 event, fast toggles on the next edge.
  - Simultaneous events on both buttons are both applied in the same cycle.
- Tick generator:
  - Period P = CLK_DIV when fast=0; P = max(CLK_DIV>>1, 1) when fast=1.
  - Counter runs 0..P-1, wraps, and emits a 1-cycle tick at P-1.
  - Any change of mode or fast clears the counter to 0. The next tick is then exactly P cycles later.
- LED output, registered one cycle after mode/state:
  - OFF: led = 0.
  - SOLID: led = all ones.
  - BLINK: led = {LED_W{phase}}. phase toggles on each tick. Entering BLINK sets phase=1.
  - CHASE: led = one-hot pattern that rotates left by one on each tick, with the MSB wrapping to bit 0. Entering CHASE sets pattern=1 (bit 0).
- End-to-end latency:
  - Raw press edge to mode change: 2 (sync) + DEBOUNCE + 1 cycles.
  - LED follows 1 cycle after mode.
- Counters are sized by $clog2 of their maxima. No overflow is possible.

Test Plan (LED_W=3, CLK_DIV=8, DEBOUNCE=4):
1. Reset: hold rst 3 cycles with buttons=1 -> led=000, mode=0, fast=0. Release rst -> outputs unchanged for 50 cycles.
2. Press button_0 low for 20 cycles, then release -> mode=1 exactly 7 cycles after the raw falling edge, led=111 one cycle later. Release causes no change.
3. Glitch: button_0 low for 3 cycles -> no mode change. Low for 6 cycles -> one advance only.
4. BLINK: advance to mode=2 -> led=111 for 8 cycles, 000 for 8 cycles, repeating. Press button_1 -> fast=1, half-period becomes 4 cycles measured from the toggle.
5. CHASE: advance to mode=3 -> led sequence 001, 010, 100, 001, each held 8 cycles (4 when fast). A 4th button_0 press returns mode=0, led=000.
6. Simultaneous press of both buttons in mode=3 with fast=1 -> same edge gives mode=0, fast=0. Assert rst mid-CHASE -> next edge gives all reset values.
